// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath constants, sample type and pair-buffer state encoding
package fft_pkg;

    localparam int DW     = 16;
    localparam int N_LOG2 = 9;
    localparam int N_HALF = 1 << (N_LOG2 - 1);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // FILL: first half of the frame is being stored; PAIR: second half is streaming out as pairs
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PAIR = 1'b1
    } pair_state_t;

endpackage

// File: rtl/fft_half_ram.sv
// rtl/fft_half_ram.sv - half-frame sample store, simple dual-port, synchronous read
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr       read request; rd_data is valid the following cycle and holds otherwise
module fft_half_ram #(
    parameter int AW = 8,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the array itself still maps onto block RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_pair_buffer.sv
// rtl/fft_pair_buffer.sv - buffers first half of each frame and emits (x[k], x[k+N/2]) pairs to butterfly2
//
// Optional build macro: PAIR_SOF_RESYNC_EN (adds din_sof frame resynchronisation and sync_err).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   din_valid, din_r/i    serial complex sample stream
//   din_sof               start of frame (PAIR_SOF_RESYNC_EN only)
//   ce                    pair strobe, one cycle after the x[k+N/2] sample
//   dina_r/i, dinb_r/i    x[k] and x[k+N/2]
//   pair_idx              k of the presented pair
//   frame_done            pulses with the last pair of a frame
//   sync_err              pulses after a mid-frame resynchronisation
module fft_pair_buffer #(
    parameter int DW     = fft_pkg::DW,
    parameter int N_LOG2 = fft_pkg::N_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
`ifdef PAIR_SOF_RESYNC_EN
    input  logic                 din_sof,
`endif
    output logic                 ce,
    output logic signed [DW-1:0] dina_r,
    output logic signed [DW-1:0] dina_i,
    output logic signed [DW-1:0] dinb_r,
    output logic signed [DW-1:0] dinb_i,
    output logic [N_LOG2-2:0]    pair_idx,
    output logic                 frame_done,
    output logic                 sync_err
);

    import fft_pkg::*;

    localparam int                AW        = N_LOG2 - 1;
    localparam logic [N_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [N_LOG2-1:0] HALF_LAST = {1'b0, {AW{1'b1}}};

    pair_state_t       state, state_next;
    logic [N_LOG2-1:0] cnt, cnt_next;
    logic              wr_en, rd_en, issue;
    logic [AW-1:0]     wr_addr;
    logic [2*DW-1:0]   rd_data;

`ifdef PAIR_SOF_RESYNC_EN
    logic              resync;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        issue      = 1'b0;
        wr_addr    = cnt[AW-1:0];
`ifdef PAIR_SOF_RESYNC_EN
        resync     = 1'b0;
`endif
        if (din_valid) begin
`ifdef PAIR_SOF_RESYNC_EN
            // A start-of-frame sample restarts the frame; the unfinished partial frame is abandoned.
            if (din_sof) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                cnt_next   = {{(N_LOG2-1){1'b0}}, 1'b1};
                state_next = ST_FILL;
                resync     = (cnt != '0);
            end else
`endif
            begin
                cnt_next = cnt + 1'b1;
                if (state == ST_FILL) begin
                    wr_en = 1'b1;
                    if (cnt == HALF_LAST) begin
                        state_next = ST_PAIR;
                    end
                end else begin
                    // Low bits of cnt in the second half are exactly cnt - N/2.
                    rd_en = 1'b1;
                    issue = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next = ST_FILL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FILL;
            cnt        <= '0;
            ce         <= 1'b0;
            frame_done <= 1'b0;
            dinb_r     <= '0;
            dinb_i     <= '0;
            pair_idx   <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ce         <= issue;
            frame_done <= issue && (cnt == CNT_LAST);
            if (issue) begin
                dinb_r   <= din_r;
                dinb_i   <= din_i;
                pair_idx <= cnt[AW-1:0];
            end
        end
    end

`ifdef PAIR_SOF_RESYNC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= resync;
        end
    end
`else
    assign sync_err = 1'b0;
`endif

    fft_half_ram #(
        .AW (AW),
        .W  (2 * DW)
    ) u_half_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({din_r, din_i}),
        .rd_en   (rd_en),
        .rd_addr (cnt[AW-1:0]),
        .rd_data (rd_data)
    );

    assign dina_r = rd_data[2*DW-1:DW];
    assign dina_i = rd_data[DW-1:0];

endmodule

// File: tb/tb_fft_pair_buffer.sv
// tb/tb_fft_pair_buffer.sv - self-checking bench for fft_pair_buffer with N=8
module tb_fft_pair_buffer;

    localparam int DW     = 16;
    localparam int N_LOG2 = 3;
    localparam int N      = 1 << N_LOG2;
    localparam int NH     = N / 2;
`ifdef PAIR_SOF_RESYNC_EN
    localparam bit SOF_EN = 1'b1;
`else
    localparam bit SOF_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 din_valid;
    logic signed [DW-1:0] din_r, din_i;
    logic                 din_sof;
    logic                 ce, frame_done, sync_err;
    logic signed [DW-1:0] dina_r, dina_i, dinb_r, dinb_i;
    logic [N_LOG2-2:0]    pair_idx;

    fft_pair_buffer #(.DW(DW), .N_LOG2(N_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_r      (din_r),
        .din_i      (din_i),
`ifdef PAIR_SOF_RESYNC_EN
        .din_sof    (din_sof),
`endif
        .ce         (ce),
        .dina_r     (dina_r),
        .dina_i     (dina_i),
        .dinb_r     (dinb_r),
        .dinb_i     (dinb_i),
        .pair_idx   (pair_idx),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ce_cnt   = 0;
    int fd_cnt   = 0;
    int err_cnt  = 0;

    // Reference model: frame position and the stored first half, as plain arrays.
    int                   mpos;
    logic signed [DW-1:0] half_r [NH];
    logic signed [DW-1:0] half_i [NH];
    logic                 exp_ce, exp_fd, exp_err;
    logic signed [DW-1:0] exp_ar, exp_ai, exp_br, exp_bi;
    logic [N_LOG2-2:0]    exp_idx;

    typedef struct {
        bit                   v;
        logic signed [DW-1:0] r;
        bit                   ce;
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        int                   idx;
        bit                   fd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input bit v, input int r, input bit c, input int a, input int b,
                                input int idx, input bit fd);
        vec_t t;
        t.v = v; t.r = DW'(r); t.ce = c; t.a = DW'(a); t.b = DW'(b); t.idx = idx; t.fd = fd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        mpos = 0;
        exp_ce = 0; exp_fd = 0; exp_err = 0;
        exp_ar = 0; exp_ai = 0; exp_br = 0; exp_bi = 0; exp_idx = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic signed [DW-1:0] r,
                              input logic signed [DW-1:0] i);
        exp_ce = 0; exp_fd = 0; exp_err = 0;
        if (v) begin
            if (SOF_EN && s) begin
                exp_err = (mpos != 0);
                half_r[0] = r; half_i[0] = i;
                mpos = 1;
            end else if (mpos < NH) begin
                half_r[mpos] = r; half_i[mpos] = i;
                mpos++;
            end else begin
                exp_ce  = 1;
                exp_ar  = half_r[mpos-NH]; exp_ai = half_i[mpos-NH];
                exp_br  = r;               exp_bi = i;
                exp_idx = (N_LOG2-1)'(mpos - NH);
                exp_fd  = (mpos == N-1);
                mpos    = (mpos + 1) % N;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ce"}, 72'(ce), 72'(exp_ce));
        chk({tag, "_frame_done"}, 72'(frame_done), 72'(exp_fd));
        chk({tag, "_sync_err"}, 72'(sync_err), 72'(exp_err));
        chk({tag, "_data"}, 72'({dina_r, dina_i, dinb_r, dinb_i, pair_idx}),
            72'({exp_ar, exp_ai, exp_br, exp_bi, exp_idx}));
    endtask

    task automatic step(input bit v, input bit s, input logic signed [DW-1:0] r,
                        input logic signed [DW-1:0] i, input string tag);
        din_valid = v; din_sof = s; din_r = r; din_i = i;
        model_step(v, s, r, i);
        @(posedge clk);
        #1;
        if (ce) ce_cnt++;
        if (frame_done) fd_cnt++;
        if (sync_err) err_cnt++;
        check_all(tag);
    endtask

    task automatic do_reset();
        din_valid = 0; din_sof = 0;
        #2 rst = 1;
        model_reset();
        #1 check_all("rst_async");
        @(posedge clk);
        #1 check_all("rst_held");
        rst = 0;
    endtask

    initial begin
        rst = 1; din_valid = 0; din_sof = 0; din_r = 0; din_i = 0;
        model_reset();
        for (int k = 0; k < NH; k++) begin half_r[k] = 0; half_i[k] = 0; end
        #1 check_all("reset_state");
        @(posedge clk);
        #1 rst = 0;

        tbl[0]  = mk(1, 10, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 11, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 12, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 13, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 14, 1, 10, 14, 0, 0);
        tbl[5]  = mk(1, 15, 1, 11, 15, 1, 0);
        tbl[6]  = mk(1, 16, 1, 12, 16, 2, 0);
        tbl[7]  = mk(1, 17, 1, 13, 17, 3, 1);
        tbl[8]  = mk(1, 20, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 21, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 22, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 23, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 24, 1, 20, 24, 0, 0);
        tbl[13] = mk(1, 25, 1, 21, 25, 1, 0);
        tbl[14] = mk(1, 26, 1, 22, 26, 2, 0);
        tbl[15] = mk(1, 27, 1, 23, 27, 3, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-frame, then a clean frame 1..8
        for (int n = 0; n < 5; n++) step(1, 0, DW'(100 + n), DW'(-(100 + n)), "pre_rst");
        do_reset();
        ce_cnt = 0; fd_cnt = 0;
        for (int n = 1; n <= 8; n++) step(1, 0, DW'(n), DW'(-n), "after_rst");
        chk("after_rst_ce_count", 72'(ce_cnt), 72'(4));
        chk("after_rst_fd_count", 72'(fd_cnt), 72'(1));

        // Wrap boundary: table of frame A followed directly by frame B
        do_reset();
        for (int j = 0; j < 17; j++) begin
            step(tbl[j].v, 0, tbl[j].r, -tbl[j].r, "tbl");
            chk("tbl_ce", 72'(ce), 72'(tbl[j].ce));
            if (tbl[j].ce)
                chk("tbl_pair", 72'({dina_r, dina_i, dinb_r, dinb_i, pair_idx, frame_done}),
                    72'({tbl[j].a, -tbl[j].a, tbl[j].b, -tbl[j].b,
                         (N_LOG2-1)'(tbl[j].idx), tbl[j].fd}));
        end

        // Continuous stream, 3 frames, with full-scale extremes
        do_reset();
        ce_cnt = 0;
        for (int n = 0; n < 3 * N; n++) begin
            logic signed [DW-1:0] r, i;
            r = DW'($urandom); i = DW'($urandom);
            if (n == 0)  begin r = -16'sd32768; i = 16'sd32767;  end
            if (n == 4)  begin r = 16'sd32767;  i = -16'sd32768; end
            if (n == 11) begin r = -16'sd32768; i = -16'sd32768; end
            step(1, 0, r, i, "cont");
        end
        chk("cont_ce_count", 72'(ce_cnt), 72'(12));

        // Gapped input: valid toggles every cycle
        do_reset();
        ce_cnt = 0;
        for (int n = 0; n < 2 * N; n++) begin
            step(1, 0, DW'($urandom), DW'($urandom), "gap_v");
            step(0, 0, DW'($urandom), DW'($urandom), "gap_idle");
        end
        chk("gap_ce_count", 72'(ce_cnt), 72'(8));

        // Random valid pattern
        do_reset();
        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 3) != 0), 0, DW'($urandom), DW'($urandom), "rand");

`ifdef PAIR_SOF_RESYNC_EN
        // Mid-frame sof drops the partial frame; a later aligned sof is clean
        do_reset();
        err_cnt = 0; ce_cnt = 0;
        for (int n = 0; n < 6; n++) step(1, 0, DW'(200 + n), DW'(-(200 + n)), "sof_part");
        for (int n = 30; n <= 37; n++) step(1, (n == 30), DW'(n), DW'(-n), "sof_frame");
        chk("sof_err_count", 72'(err_cnt), 72'(1));
        chk("sof_ce_count", 72'(ce_cnt), 72'(6));
        for (int n = 40; n <= 47; n++) step(1, (n == 40), DW'(n), DW'(-n), "sof_aligned");
        chk("sof_aligned_err_count", 72'(err_cnt), 72'(1));
        for (int n = 0; n < 200; n++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 DW'($urandom), DW'($urandom), "sof_rand");
`endif

        step(0, 0, 0, 0, "tail");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
